// File: rtl/ariane_axi_soc.sv
// AXI4 master-port request/response types of the SoC crossbar, shared by every
// initiator that connects to it.
package ariane_axi_soc;

  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned UserWidth = 1;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [StrbWidth-1:0] strb_t;
  typedef logic [IdWidth-1:0]   id_t;
  typedef logic [UserWidth-1:0] user_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    user_t       user;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    user_t       user;
  } ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/axi_lite_master_bridge.sv
// Turns a single-outstanding req/gnt/rvalid memory port into single-beat
// AXI4-Lite transactions on an SoC master port; every AXI valid/ready is a flop.
module axi_lite_master_bridge
  import ariane_axi_soc::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
  output logic                        gnt_o,
  output logic                        rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
  output logic                        err_o,
  output ariane_axi_soc::req_t        axi_req_o,
  input  ariane_axi_soc::resp_t       axi_resp_i
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_e;

  localparam logic [2:0] AXI_SIZE   = 3'($clog2(AXI_DATA_WIDTH / 8));
  localparam logic [1:0] BURST_INCR = 2'b01;

  state_e                        state_q;
  logic [AXI_ADDR_WIDTH-1:0]     addr_q;
  logic [AXI_DATA_WIDTH-1:0]     wdata_q;
  logic [AXI_DATA_WIDTH/8-1:0]   be_q;
  logic                          aw_valid_q, w_valid_q, aw_done_q, w_done_q;
  logic                          ar_valid_q, b_ready_q, r_ready_q;
  logic                          rvalid_q, err_q;
  logic [AXI_DATA_WIDTH-1:0]     rdata_q;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic unused_resp;

  assign aw_hs = aw_valid_q & axi_resp_i.aw_ready;
  assign w_hs  = w_valid_q  & axi_resp_i.w_ready;
  assign ar_hs = ar_valid_q & axi_resp_i.ar_ready;
  assign b_hs  = b_ready_q  & axi_resp_i.b_valid;
  assign r_hs  = r_ready_q  & axi_resp_i.r_valid;

  assign unused_resp = ^{axi_resp_i.b.id, axi_resp_i.b.user, axi_resp_i.b.resp[0],
                         axi_resp_i.r.id, axi_resp_i.r.user, axi_resp_i.r.resp[0],
                         axi_resp_i.r.last};

  assign gnt_o    = req_i & (state_q == IDLE);
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  // AW and W may complete in either order or together; each owns a done bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            be_q    <= be_i;
            if (we_i) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              aw_done_q  <= 1'b0;
              w_done_q   <= 1'b0;
              state_q    <= WR_ADDR_DATA;
            end else begin
              ar_valid_q <= 1'b1;
              state_q    <= RD_ADDR;
            end
          end
        end
        WR_ADDR_DATA: begin
          if (aw_hs) begin
            aw_valid_q <= 1'b0;
            aw_done_q  <= 1'b1;
          end
          if (w_hs) begin
            w_valid_q <= 1'b0;
            w_done_q  <= 1'b1;
          end
          if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
            b_ready_q <= 1'b1;
            state_q   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            b_ready_q <= 1'b0;
            err_q     <= axi_resp_i.b.resp[1];
            rdata_q   <= '0;
            rvalid_q  <= 1'b1;
            state_q   <= RESP;
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            r_ready_q <= 1'b0;
            rdata_q   <= axi_resp_i.r.data;
            err_q     <= axi_resp_i.r.resp[1];
            rvalid_q  <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP: begin
          rvalid_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.id    = AXI_ID_WIDTH'(AXI_ID);
    axi_req_o.aw.addr  = addr_q;
    axi_req_o.aw.size  = AXI_SIZE;
    axi_req_o.aw.burst = BURST_INCR;
    axi_req_o.aw_valid = aw_valid_q;
    axi_req_o.w.data   = wdata_q;
    axi_req_o.w.strb   = be_q;
    axi_req_o.w.last   = 1'b1;
    axi_req_o.w_valid  = w_valid_q;
    axi_req_o.b_ready  = b_ready_q;
    axi_req_o.ar.id    = AXI_ID_WIDTH'(AXI_ID);
    axi_req_o.ar.addr  = addr_q;
    axi_req_o.ar.size  = AXI_SIZE;
    axi_req_o.ar.burst = BURST_INCR;
    axi_req_o.ar_valid = ar_valid_q;
    axi_req_o.r_ready  = r_ready_q;
  end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Drives the bridge with directed and random transactions against a timing and
// data model of single-beat AXI4-Lite transfers.
module tb_axi_lite_master_bridge;

  localparam int unsigned TB_AXI_ID = 5;

  logic                  clk_i;
  logic                  rst_ni;
  logic                  req_i;
  logic                  we_i;
  logic [63:0]           addr_i;
  logic [63:0]           wdata_i;
  logic [7:0]            be_i;
  logic                  gnt_o;
  logic                  rvalid_o;
  logic [63:0]           rdata_o;
  logic                  err_o;
  ariane_axi_soc::req_t  axi_req;
  ariane_axi_soc::resp_t axi_resp;

  int vectors;
  int miscompares;
  logic [63:0] lastRdata;
  logic        lastErr;

  axi_lite_master_bridge #(
    .AXI_ADDR_WIDTH(64),
    .AXI_DATA_WIDTH(64),
    .AXI_ID_WIDTH  (4),
    .AXI_ID        (TB_AXI_ID)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .be_i      (be_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .axi_req_o (axi_req),
    .axi_resp_i(axi_resp)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // d0/d1/d2: AW/W/B delays for a write, AR/unused/R delays for a read.
  // data is the write data, or the data the slave returns for a read.
  task automatic applyStimulus(input logic we, input logic [63:0] addr, input logic [63:0] data,
                               input logic [7:0] be, input int d0, input int d1, input int d2,
                               input logic [1:0] resp, input logic holdReq);
    int ta, tw, tm, tResp, tEnd;
    int awBeats, wBeats, arBeats;
    logic [5:0] expFlags;
    ta = 1 + d0;
    tw = we ? 1 + d1 : ta;
    tm = (ta > tw) ? ta : tw;
    tResp = tm + 1 + d2;
    tEnd = tResp + 1;
    awBeats = 0; wBeats = 0; arBeats = 0;
    for (int k = 0; k <= tEnd; k++) begin
      @(negedge clk_i);
      req_i   = (k == 0) || holdReq;
      we_i    = we;
      addr_i  = addr;
      wdata_i = data;
      be_i    = be;
      axi_resp = '0;
      if (we) begin
        axi_resp.aw_ready = (k >= ta);
        axi_resp.w_ready  = (k >= tw);
        axi_resp.b_valid  = (k == tResp);
        axi_resp.b.resp   = resp;
        axi_resp.b.id     = 4'(TB_AXI_ID);
      end else begin
        axi_resp.ar_ready = (k >= ta);
        axi_resp.r_valid  = (k == tResp);
        axi_resp.r.data   = data;
        axi_resp.r.resp   = resp;
        axi_resp.r.last   = 1'b1;
        axi_resp.r.id     = 4'(TB_AXI_ID);
      end
      #1;
      if (k == 0) begin
        checkOutput("rdata_hold", rdata_o, lastRdata);
        checkOutput("err_hold", 64'(err_o), 64'(lastErr));
      end
      if (req_i) checkOutput("gnt", 64'(gnt_o), 64'(k == 0));
      expFlags = {we && k >= 1 && k <= ta,
                  we && k >= 1 && k <= tw,
                  !we && k >= 1 && k <= ta,
                  we && k > tm && k <= tResp,
                  !we && k > ta && k <= tResp,
                  k == tEnd};
      checkOutput("handshake", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid,
                                    axi_req.b_ready, axi_req.r_ready, rvalid_o}), 64'(expFlags));
      if (axi_req.aw_valid && axi_resp.aw_ready) awBeats++;
      if (axi_req.w_valid && axi_resp.w_ready) wBeats++;
      if (axi_req.ar_valid && axi_resp.ar_ready) arBeats++;
      if (expFlags[5]) begin
        checkOutput("aw_addr", axi_req.aw.addr, addr);
        checkOutput("aw_ctrl", 64'({axi_req.aw.len, axi_req.aw.size, axi_req.aw.burst, axi_req.aw.id,
                                    axi_req.aw.lock, axi_req.aw.cache, axi_req.aw.prot, axi_req.aw.qos,
                                    axi_req.aw.region, axi_req.aw.atop, axi_req.aw.user}),
                    64'({8'd0, 3'd3, 2'd1, 4'(TB_AXI_ID), 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0, 1'b0}));
      end
      if (expFlags[4]) begin
        checkOutput("w_data", axi_req.w.data, data);
        checkOutput("w_strb_last", 64'({axi_req.w.strb, axi_req.w.last, axi_req.w.user}),
                    64'({be, 1'b1, 1'b0}));
      end
      if (expFlags[3]) begin
        checkOutput("ar_addr", axi_req.ar.addr, addr);
        checkOutput("ar_ctrl", 64'({axi_req.ar.len, axi_req.ar.size, axi_req.ar.burst, axi_req.ar.id,
                                    axi_req.ar.lock, axi_req.ar.cache, axi_req.ar.prot, axi_req.ar.qos,
                                    axi_req.ar.region, axi_req.ar.user}),
                    64'({8'd0, 3'd3, 2'd1, 4'(TB_AXI_ID), 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0}));
      end
      if (k == tEnd) begin
        lastRdata = we ? 64'd0 : data;
        lastErr   = resp[1];
        checkOutput("rdata", rdata_o, lastRdata);
        checkOutput("err", 64'(err_o), 64'(lastErr));
      end
    end
    checkOutput("beats", 64'({awBeats[7:0], wBeats[7:0], arBeats[7:0]}),
                64'({we ? 8'd1 : 8'd0, we ? 8'd1 : 8'd0, we ? 8'd0 : 8'd1}));
  endtask

  // Reset lands in the middle of a write whose slave never becomes ready
  task automatic resetMidWrite();
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1;
    addr_i = {$urandom, $urandom}; wdata_i = {$urandom, $urandom}; be_i = 8'hFF;
    axi_resp = '0;
    #1 checkOutput("rst_gnt", 64'(gnt_o), 64'd1);
    @(negedge clk_i);
    req_i = 1'b0;
    #1 checkOutput("rst_pre_valids", 64'({axi_req.aw_valid, axi_req.w_valid}), 64'h3);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("rst_async_valids", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid,
                                         axi_req.b_ready, axi_req.r_ready, rvalid_o}), 64'd0);
    checkOutput("rst_async_rdata", rdata_o, 64'd0);
    checkOutput("rst_async_err", 64'(err_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    lastRdata = '0;
    lastErr   = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    lastRdata = '0; lastErr = 1'b0;
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0;
    addr_i = '0; wdata_i = '0; be_i = '0;
    axi_resp = '0;
    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("reset_flags", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid,
                                    axi_req.b_ready, axi_req.r_ready, rvalid_o, gnt_o}), 64'd0);
    checkOutput("reset_rdata", rdata_o, 64'd0);
    checkOutput("reset_err", 64'(err_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    $display("[TB] directed transactions");
    applyStimulus(1'b0, 64'h1000, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 0, 0, 2'b00, 1'b0);
    applyStimulus(1'b1, 64'h2008, 64'h55, 8'h0F, 0, 0, 0, 2'b00, 1'b0);
    applyStimulus(1'b1, 64'h3000, 64'h1234_5678_9ABC_DEF0, 8'hA5, 4, 0, 0, 2'b00, 1'b0);
    applyStimulus(1'b1, 64'h3008, 64'h0FED_CBA9_8765_4321, 8'h3C, 0, 4, 0, 2'b00, 1'b0);
    applyStimulus(1'b0, 64'h4010, 64'h1111_2222_3333_4444, 8'hFF, 10, 0, 10, 2'b00, 1'b1);
    applyStimulus(1'b1, 64'h4018, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, 0, 0, 10, 2'b00, 1'b1);
    applyStimulus(1'b0, 64'h5000, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, 0, 0, 0, 2'b10, 1'b0);
    applyStimulus(1'b1, 64'h5008, 64'h77, 8'h01, 0, 0, 0, 2'b11, 1'b0);
    applyStimulus(1'b0, 64'h5010, 64'h6666_7777_8888_9999, 8'hFF, 1, 0, 2, 2'b01, 1'b0);

    $display("[TB] random transactions");
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                    8'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset during write");
    resetMidWrite();
    applyStimulus(1'b0, 64'h6000, 64'hFACE_B00C_0000_0001, 8'hFF, 0, 0, 0, 2'b00, 1'b0);

    @(negedge clk_i);
    req_i = 1'b0;
    axi_resp = '0;
    #1;
    checkOutput("final_rvalid", 64'(rvalid_o), 64'd0);
    checkOutput("final_rdata_hold", rdata_o, lastRdata);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_bridge.md
# axi_lite_master_bridge

Converts a simple single-outstanding, memory-like request port (req/gnt/rvalid) into AXI4-Lite-compliant single-beat transactions on an `ariane_axi_soc` master port. It is the initiator counterpart of the SoC's AXI-Lite register slaves. Small peripherals and debug logic use it to reach the AXI crossbar without their own AXI state machines.

## Interface
- AXI_ADDR_WIDTH, 64, address width of `addr_i` and AR/AW addr
- AXI_DATA_WIDTH, 64, data width; `be_i` width is AXI_DATA_WIDTH/8
- AXI_ID_WIDTH, 4, width of the ID field driven on AR/AW
- AXI_ID, 0, constant ID driven on every AR/AW
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  1  request valid
- we_i  in  1  1 = write, 0 = read
- addr_i  in  AXI_ADDR_WIDTH  byte address
- wdata_i  in  AXI_DATA_WIDTH  write data
- be_i  in  AXI_DATA_WIDTH/8  byte enables, driven onto w.strb
- gnt_o  out  1  request accepted this cycle
- rvalid_o  out  1  one-cycle response pulse, for reads and writes
- rdata_o  out  AXI_DATA_WIDTH  read data, valid with rvalid_o
- err_o  out  1  response error (bresp/rresp[1]), valid with rvalid_o
- axi_req_o  out  ariane_axi_soc::req_t  AXI master request
- axi_resp_i  in  ariane_axi_soc::resp_t  AXI master response

## Operation
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - `gnt_o = req_i` (combinational).
  - On `req_i`, latch addr, wdata, be and we.
  - Next state is WR_ADDR_DATA if we_i is set, otherwise RD_ADDR.
- WR_ADDR_DATA:
  - aw_valid and w_valid are both driven from registers. Each flag drops independently after its own handshake (two "done" bits).
  - Once both handshakes have completed, including the case where both happen in the same cycle, go to WR_RESP.
  - AW and W ordering is not assumed.
- WR_RESP:
  - b_ready = 1.
  - On b_valid, latch err = b.resp[1] and rdata = '0, then go to RESP.
- RD_ADDR: ar_valid = 1; on ar_ready, go to RD_DATA.
- RD_DATA:
  - r_ready = 1.
  - On r_valid, latch rdata = r.data and err = r.resp[1], then go to RESP.
- RESP: rvalid_o = 1 for exactly one cycle, then return to IDLE.
- Fixed AW/AR fields: len = 0, size = $clog2(AXI_DATA_WIDTH/8), burst = INCR, id = AXI_ID.
- Fixed AW/AR fields, all zero: lock, cache, prot, qos, region, atop, user.
- W fields: w.last = 1, w.strb = latched be, w.data = latched wdata.
- AXI valids never depend combinationally on any ready. Each valid, once raised, stays high with stable payload until its handshake.
- gnt_o = 0 in every state other than IDLE.
- Exactly one transaction is outstanding at a time.
- Response IDs are not checked.

## Timing
- Reset values:
  - state = IDLE.
  - All AXI valids and readies = 0.
  - gnt_o = 0 (req_i is gated by IDLE; reset forces IDLE).
  - rvalid_o = 0, rdata_o = '0, err_o = 0.
- Minimum write latency with the slave always ready:
  - Cycle 0: grant.
  - Cycle 1: AW/W handshake.
  - Cycle 2: B handshake.
  - Cycle 3: rvalid_o.
  - Total: 3 cycles from grant to rvalid_o.
- Minimum read latency: 3 cycles (grant, AR handshake, R handshake, rvalid_o).
- Throughput: at most one transaction every 4 cycles. The next grant is possible in the cycle after RESP.
- rdata_o and err_o hold their last value until the next response.
- Reset asserted mid-transaction:
  - All state clears immediately (asynchronous). Any in-flight AXI valid drops.
  - The transaction is abandoned; a system-level reset is assumed.
- A req_i held high outside IDLE is simply not granted; the requester keeps its payload stable until gnt_o.

## Structure
- Use the existing `ariane_axi_soc` req_t/resp_t types; no new package types.
- The FSM state enum and the size constant are module-local.
- Single module, no sub-module; the AW and W done-flags stay inline.

## Test plan
- Read, slave always ready, addr 0x1000:
  - ar.addr = 0x1000, len = 0, id = AXI_ID.
  - r.data 0xDEADBEEF_CAFEF00D returns with rvalid_o 3 cycles after grant, err_o = 0.
- Write addr 0x2008, wdata 0x55, be 0x0F:
  - aw.addr = 0x2008, w.strb = 0x0F, w.last = 1.
  - rvalid_o 3 cycles after grant, rdata_o = 0.
- Write with W ready 4 cycles before AW ready, then with AW ready first:
  - Each valid deasserts only after its own handshake.
  - Exactly one AW and one W beat are issued; rvalid_o is issued once.
- Backpressure:
  - Hold ar_ready, r_valid and b_valid low for 10 random cycles.
  - Valids and payload stay stable; gnt_o stays 0 for a new req_i throughout.
- Error response:
  - rresp = SLVERR (2'b10) gives err_o = 1 with rvalid_o.
  - bresp = DECERR (2'b11) gives err_o = 1.
- Reset asserted while in WR_ADDR_DATA:
  - aw_valid and w_valid drop asynchronously; the block is back in IDLE.
  - A subsequent read completes normally.
